// File: rtl/fetch_instruccion_micro.sv
// Instruction fetch stage: PC, ROM req/ack read with timeout,
// registered instruction output under a valid/ready handshake.
module fetch_instruccion_micro #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int TO_CYC = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_jump,
    input  logic [AW-1:0] i_jump_addr,
    output logic          o_rom_req,
    output logic [AW-1:0] o_rom_addr,
    input  logic          i_rom_ack,
    input  logic [DW-1:0] i_rom_data,
    output logic [DW-1:0] o_instruccion,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [AW-1:0] o_pc,
    output logic          o_err
);
    localparam int CW = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t        r_state, w_state;
    logic [AW-1:0] r_pc, w_pc;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_req, w_req;
    logic [AW-1:0] r_addr, w_addr;
    logic [DW-1:0] r_instr, w_instr;
    logic          r_valid, w_valid;
    logic [AW-1:0] r_opc, w_opc;
    logic          r_err, w_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_opc   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_pc    <= w_pc;
            r_cnt   <= w_cnt;
            r_req   <= w_req;
            r_addr  <= w_addr;
            r_instr <= w_instr;
            r_valid <= w_valid;
            r_opc   <= w_opc;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_pc    = r_pc;
        w_cnt   = r_cnt;
        w_req   = r_req;
        w_addr  = r_addr;
        w_instr = r_instr;
        w_valid = r_valid;
        w_opc   = r_opc;
        w_err   = 1'b0;
        if (i_jump) begin
            w_pc    = i_jump_addr;
            w_valid = 1'b0;
            w_req   = 1'b0;
            w_cnt   = '0;
            w_state = i_en ? S_REQ : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        w_state = S_REQ;
                        w_req   = 1'b1;
                        w_addr  = r_pc;
                        w_cnt   = '0;
                    end
                end
                S_REQ: begin
                    // req low here means a fresh entry or the post-timeout gap
                    if (!r_req) begin
                        w_req  = 1'b1;
                        w_addr = r_pc;
                    end else if (i_rom_ack) begin
                        w_instr = i_rom_data;
                        w_opc   = r_pc;
                        w_valid = 1'b1;
                        w_pc    = r_pc + AW'(1);
                        w_req   = 1'b0;
                        w_cnt   = '0;
                        w_state = S_HOLD;
                    end else if (r_cnt == CW'(TO_CYC)) begin
                        w_err = 1'b1;
                        w_req = 1'b0;
                        w_cnt = '0;
                    end else begin
                        w_cnt = r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (i_ready) begin
                        w_valid = 1'b0;
                        w_state = i_en ? S_REQ : S_IDLE;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    assign o_rom_req     = r_req;
    assign o_rom_addr    = r_addr;
    assign o_instruccion = r_instr;
    assign o_valid       = r_valid;
    assign o_pc          = r_opc;
    assign o_err         = r_err;
endmodule

// File: tb/tb_fetch_instruccion_micro.sv
// Directed bench for fetch_instruccion_micro: handshakes, wrap,
// jump-vs-ack, ack timeout and asynchronous reset.
module tb_fetch_instruccion_micro;
    logic       clk = 1'b0;
    logic       rst_n, en, jump, ack, ready;
    logic [7:0] jaddr, rom_data, rom_addr, instr, opc;
    logic       req, valid, err;
    int         npass = 0;
    int         ntot = 0;

    always #5 clk = ~clk;

    // ROM contents: A5 at address 0, otherwise address xor 3C
    assign rom_data = (rom_addr == 8'h00) ? 8'hA5 : (rom_addr ^ 8'h3C);

    fetch_instruccion_micro dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_jump(jump), .i_jump_addr(jaddr),
        .o_rom_req(req), .o_rom_addr(rom_addr),
        .i_rom_ack(ack), .i_rom_data(rom_data),
        .o_instruccion(instr), .o_valid(valid),
        .i_ready(ready), .o_pc(opc), .o_err(err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; jump = 1'b0; jaddr = 8'h00;
        ack = 1'b0; ready = 1'b1;
        #12;
        chk("rst_req", 16'(req), 16'h0);
        chk("rst_addr", 16'(rom_addr), 16'h0);
        chk("rst_instr", 16'(instr), 16'h0);
        chk("rst_valid", 16'(valid), 16'h0);
        chk("rst_pc", 16'(opc), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        rst_n = 1'b1;
        tick();

        // 1: zero-wait fetch of A5 at address 0
        en = 1'b1;
        tick();
        chk("t1_req", 16'(req), 16'h1);
        chk("t1_addr", 16'(rom_addr), 16'h00);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_valid", 16'(valid), 16'h1);
        chk("t1_instr", 16'(instr), 16'hA5);
        chk("t1_pc", 16'(opc), 16'h00);
        chk("t1_reqlow", 16'(req), 16'h0);
        tick();
        chk("t1_valid_drop", 16'(valid), 16'h0);
        chk("t1_gap_req", 16'(req), 16'h0);
        tick();
        chk("t1_next_req", 16'(req), 16'h1);
        chk("t1_next_addr", 16'(rom_addr), 16'h01);

        // 2: ack delayed 3 cycles, consumer stalls 4 cycles
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_req_hold", 16'(req), 16'h1);
            chk("t2_addr_hold", 16'(rom_addr), 16'h01);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_valid", 16'(valid), 16'h1);
        chk("t2_instr", 16'(instr), 16'h3D);
        chk("t2_pc", 16'(opc), 16'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall_valid", 16'(valid), 16'h1);
            chk("t2_stall_instr", 16'(instr), 16'h3D);
            chk("t2_stall_noreq", 16'(req), 16'h0);
        end
        ready = 1'b1;
        tick();
        chk("t2_xfer", 16'(valid), 16'h0);

        // 3: PC wrap from FF
        jump = 1'b1; jaddr = 8'hFF;
        tick();
        jump = 1'b0;
        tick();
        chk("t3_req", 16'(req), 16'h1);
        chk("t3_addr", 16'(rom_addr), 16'hFF);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_instr", 16'(instr), 16'hC3);
        chk("t3_pc", 16'(opc), 16'hFF);
        tick();
        tick();
        chk("t3_wrap_req", 16'(req), 16'h1);
        chk("t3_wrap_addr", 16'(rom_addr), 16'h00);

        // 4: jump coinciding with ack discards the data
        ack = 1'b1; jump = 1'b1; jaddr = 8'h40;
        tick();
        ack = 1'b0; jump = 1'b0;
        chk("t4_valid", 16'(valid), 16'h0);
        chk("t4_instr", 16'(instr), 16'hC3);
        chk("t4_req", 16'(req), 16'h0);
        tick();
        chk("t4_req2", 16'(req), 16'h1);
        chk("t4_addr", 16'(rom_addr), 16'h40);

        // 5: no ack -> timeout every 17 cycles
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 15; i++) begin
                tick();
                chk("t5_wait_req", 16'(req), 16'h1);
                chk("t5_wait_err", 16'(err), 16'h0);
            end
            tick();
            chk("t5_err", 16'(err), 16'h1);
            chk("t5_req_gap", 16'(req), 16'h0);
            tick();
            chk("t5_err_pulse", 16'(err), 16'h0);
            chk("t5_rereq", 16'(req), 16'h1);
            chk("t5_readdr", 16'(rom_addr), 16'h40);
        end

        // 6: async reset with valid pending, then mid-request
        ack = 1'b1; ready = 1'b0;
        tick();
        ack = 1'b0;
        chk("t6_valid", 16'(valid), 16'h1);
        chk("t6_instr", 16'(instr), 16'h7C);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 16'(valid), 16'h0);
        chk("t6_rst_instr", 16'(instr), 16'h00);
        chk("t6_rst_pc", 16'(opc), 16'h00);
        rst_n = 1'b1; ready = 1'b1;
        tick();
        chk("t6_restart_req", 16'(req), 16'h1);
        chk("t6_restart_addr", 16'(rom_addr), 16'h00);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 16'(req), 16'h0);
        rst_n = 1'b1;
        tick();
        chk("t6_req_again", 16'(req), 16'h1);
        chk("t6_addr_again", 16'(rom_addr), 16'h00);

        // en=0 lets the current fetch finish, then stays idle
        en = 1'b0; ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t7_instr", 16'(instr), 16'hA5);
        chk("t7_valid", 16'(valid), 16'h1);
        tick();
        chk("t7_xfer", 16'(valid), 16'h0);
        tick();
        tick();
        chk("t7_idle", 16'(req), 16'h0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
